// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants and types for the configuration register arbiter
package cfg_pkg;

  localparam int CFG_ADDR_W = 7;
  localparam int CFG_DATA_W = 8;

  localparam logic [CFG_ADDR_W-1:0] ADDR_OUT_LO = 7'h00;
  localparam logic [CFG_ADDR_W-1:0] ADDR_OUT_HI = 7'h01;
  localparam logic [CFG_ADDR_W-1:0] ADDR_PWM_LO = 7'h02;
  localparam logic [CFG_ADDR_W-1:0] ADDR_PWM_HI = 7'h03;
  localparam logic [CFG_ADDR_W-1:0] ADDR_DUTY   = 7'h04;
  localparam int                    NUM_REGS    = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic addr_invalid(input logic [CFG_ADDR_W-1:0] addr);
    return addr >= CFG_ADDR_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector with a registered last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_idx,
  output logic       gnt_idx,
  output logic       gnt_any
);

  // Reset to "requester 1 granted last" so requester 0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= update_idx;
    end
  end

  always_comb begin
    gnt_any = |req;
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// rtl/cfg_reg_arbiter.sv - arbitrated config register bank with period-aligned duty commit
// Optional invalid-address counter (err_cnt) is built when CFG_ARB_ERR_CNT_EN is defined.
module cfg_reg_arbiter
  import cfg_pkg::*;
#(
  parameter int          ADDR_W   = CFG_ADDR_W,
  parameter int          DATA_W   = CFG_DATA_W,
  parameter logic [7:0]  DUTY_RST = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  input  logic              period_start,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              duty_pending,
  output logic              busy
`ifdef CFG_ARB_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  state_t  state_q, state_d;
  wr_req_t req_q, req_sel;
  logic    gnt_q;
  logic    gnt_idx, gnt_any;
  logic    wr_en;
  logic [7:0] duty_shadow;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst        (rst),
    .req        ({req1_valid, req0_valid}),
    .update     (wr_en),
    .update_idx (gnt_q),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  always_comb begin
    req_sel.addr = gnt_idx ? CFG_ADDR_W'(req1_addr) : CFG_ADDR_W'(req0_addr);
    req_sel.data = gnt_idx ? CFG_DATA_W'(req1_data) : CFG_DATA_W'(req0_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_any) begin
        req_q <= req_sel;
        gnt_q <= gnt_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    req0_ack = 1'b0;
    req1_ack = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (gnt_any) state_d = WRITE;
      end
      WRITE: begin
        wr_en    = 1'b1;
        req0_ack = ~gnt_q;
        req1_ack = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
    end else if (wr_en) begin
      case (req_q.addr)
        ADDR_OUT_LO: en_reg_out_7_0  <= req_q.data;
        ADDR_OUT_HI: en_reg_out_15_8 <= req_q.data;
        ADDR_PWM_LO: en_reg_pwm_7_0  <= req_q.data;
        ADDR_PWM_HI: en_reg_pwm_15_8 <= req_q.data;
        default: ;
      endcase
    end
  end

  // Commit reads the shadow before this edge; a coincident duty write then re-arms pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow    <= DUTY_RST;
      pwm_duty_cycle <= DUTY_RST;
      duty_pending   <= 1'b0;
    end else begin
      if (period_start && duty_pending) begin
        pwm_duty_cycle <= duty_shadow;
        duty_pending   <= 1'b0;
      end
      if (wr_en && req_q.addr == ADDR_DUTY) begin
        duty_shadow  <= req_q.data;
        duty_pending <= 1'b1;
      end
    end
  end

`ifdef CFG_ARB_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (wr_en && addr_invalid(req_q.addr) && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb/tb_cfg_reg_arbiter.sv - table-driven self-checking bench for cfg_reg_arbiter
module tb_cfg_reg_arbiter;

  localparam logic [7:0] DR = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ack, req1_ack;
  logic       period_start = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       duty_pending, busy;
`ifdef CFG_ARB_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_reg_arbiter #(.ADDR_W(7), .DATA_W(8), .DUTY_RST(DR)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_data       (req0_data),
    .req0_ack        (req0_ack),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_data       (req1_data),
    .req1_ack        (req1_ack),
    .period_start    (period_start),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .duty_pending    (duty_pending),
    .busy            (busy)
`ifdef CFG_ARB_ERR_CNT_EN
    ,
    .err_cnt         (err_cnt)
`endif
  );

  // kind: 0 = write by req0, 1 = write by req1, 2 = period_start pulse only
  typedef struct {
    int         kind;
    logic [6:0] addr;
    logic [7:0] data;
    logic       ps;
    logic [7:0] e_lo, e_hi, e_plo, e_phi, e_duty;
    logic       e_pend;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] lo, hi, plo, phi, duty,
                          input logic pend);
    chk({tag, " out_7_0"},  en_reg_out_7_0,  lo);
    chk({tag, " out_15_8"}, en_reg_out_15_8, hi);
    chk({tag, " pwm_7_0"},  en_reg_pwm_7_0,  plo);
    chk({tag, " pwm_15_8"}, en_reg_pwm_15_8, phi);
    chk({tag, " duty"},     pwm_duty_cycle,  duty);
    chk({tag, " pending"},  duty_pending,    pend);
  endtask

  task automatic do_write(input int who, input logic [6:0] addr, input logic [7:0] data,
                          input logic ps);
    @(negedge clk);
    if (who == 0) begin
      req0_valid = 1'b1; req0_addr = addr; req0_data = data;
    end else begin
      req1_valid = 1'b1; req1_addr = addr; req1_data = data;
    end
    @(negedge clk);
    chk("ack_latency", (who == 0) ? req0_ack : req1_ack, 1'b1);
    chk("ack_other",   (who == 0) ? req1_ack : req0_ack, 1'b0);
    chk("busy_write",  busy, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    period_start = ps;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  task automatic pulse_ps();
    @(negedge clk);
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0, 7'h00, 8'hA5, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, DR,    1'b0};
    tbl[1]  = '{1, 7'h03, 8'h3C, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, DR,    1'b0};
    tbl[2]  = '{0, 7'h04, 8'h80, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, DR,    1'b1};
    tbl[3]  = '{2, 7'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h80, 1'b0};
    tbl[4]  = '{2, 7'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h80, 1'b0};
    tbl[5]  = '{0, 7'h04, 8'h90, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h80, 1'b1};
    tbl[6]  = '{1, 7'h04, 8'h40, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h90, 1'b1};
    tbl[7]  = '{2, 7'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h40, 1'b0};
    tbl[8]  = '{0, 7'h04, 8'h11, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h40, 1'b1};
    tbl[9]  = '{1, 7'h04, 8'h22, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h40, 1'b1};
    tbl[10] = '{2, 7'h00, 8'h00, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h22, 1'b0};
    tbl[11] = '{0, 7'h7F, 8'hFF, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h22, 1'b0};
    tbl[12] = '{1, 7'h05, 8'h77, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h22, 1'b0};
    tbl[13] = '{1, 7'h02, 8'hC3, 1'b0, 8'hA5, 8'h00, 8'hC3, 8'h3C, 8'h22, 1'b0};

    repeat (3) @(negedge clk);
    chk_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, DR, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset ack0", req0_ack, 1'b0);
    chk("reset ack1", req1_ack, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].kind == 2) pulse_ps();
      else do_write(tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].ps);
      chk_regs($sformatf("vec%0d", i), tbl[i].e_lo, tbl[i].e_hi, tbl[i].e_plo,
               tbl[i].e_phi, tbl[i].e_duty, tbl[i].e_pend);
`ifdef CFG_ARB_ERR_CNT_EN
      if (i == 12) chk("err_cnt two", err_cnt, 8'h02);
`endif
    end

    // Tie after a req1 grant: req0 wins; req0 re-requests at once so the next tie goes to req1.
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 7'h01; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'h02; req1_data = 8'h22;
    @(negedge clk);
    chk("tie1 ack0", req0_ack, 1'b1);
    chk("tie1 ack1", req1_ack, 1'b0);
    req0_addr = 7'h00; req0_data = 8'h5C;
    @(negedge clk);
    chk("tie idle busy", busy, 1'b0);
    chk("tie out_15_8", en_reg_out_15_8, 8'h11);
    @(negedge clk);
    chk("tie2 ack1", req1_ack, 1'b1);
    chk("tie2 ack0", req0_ack, 1'b0);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("tie pwm_7_0", en_reg_pwm_7_0, 8'h22);
    @(negedge clk);
    chk("tie3 ack0", req0_ack, 1'b1);
    req0_valid = 1'b0;
    @(negedge clk);
    chk_regs("tie final", 8'h5C, 8'h11, 8'h22, 8'h3C, 8'h22, 1'b0);

`ifdef CFG_ARB_ERR_CNT_EN
    for (int i = 0; i < 300; i++) do_write(i % 2, 7'h40 + 7'(i % 60), 8'hEE, 1'b0);
    chk("err_cnt saturate", err_cnt, 8'hFF);
    chk_regs("after invalid", 8'h5C, 8'h11, 8'h22, 8'h3C, 8'h22, 1'b0);
`endif

    // Reset lands inside the WRITE cycle of a 0x5A write to addr 0x03.
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 7'h03; req1_data = 8'h5A;
    @(posedge clk);
    #2;
    chk("midwrite busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst ack1", req1_ack, 1'b0);
    chk("rst busy", busy, 1'b0);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("rst hold ack1", req1_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_regs("post reset", 8'h00, 8'h00, 8'h00, 8'h00, DR, 1'b0);
    chk("pwm_15_8 not 5A", (en_reg_pwm_15_8 != 8'h5A), 1'b1);
    chk("post reset ack1", req1_ack, 1'b0);
    chk("post reset busy", busy, 1'b0);
`ifdef CFG_ARB_ERR_CNT_EN
    chk("post reset err_cnt", err_cnt, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
